// File: rtl/unary_mult_scheduler.sv
// Round-robin front end that serialises binary operand pairs into unary streams for a
// shared unary multiplier, counts the unary product and hands back one response per job.
module unary_mult_scheduler #(
  parameter int BIN_BITS     = 4,
  parameter int NUM_REQ      = 4,
  parameter int DRAIN_CYCLES = (1 << BIN_BITS) * (1 << BIN_BITS) + 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BIN_BITS-1:0]   req_a,
  input  logic [NUM_REQ*BIN_BITS-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mul_in_a,
  output logic                          mul_in_b,
  output logic                          mul_in_valid,
  input  logic                          mul_out,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [2*BIN_BITS-1:0]         resp_product,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int U_BITS = 1 << BIN_BITS;
  localparam int IW     = $clog2(NUM_REQ);
  localparam int PW     = 2 * BIN_BITS;

  // Handshakes: a request transfers on a cycle with req_valid[i] && req_ready[i];
  // a response transfers on a cycle with resp_valid && resp_ready. Payloads hold while valid.
  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [31:0]           cyc_q, cyc_d;
  logic [BIN_BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]         id_q, id_d, ptr_q, ptr_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic                  mul_in_a_q, mul_in_a_d, mul_in_b_q, mul_in_b_d;
  logic                  mul_in_valid_q, mul_in_valid_d;

  logic                  gnt_found;
  logic [IW-1:0]         gnt_idx;
  logic [BIN_BITS-1:0]   sel_a, sel_b;

  // Search starts at the pointer, which always holds (last granted + 1) mod NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid[(int'(ptr_q) + j) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(ptr_q) + j) % NUM_REQ);
      end
    end
  end

  assign sel_a = req_a[gnt_idx*BIN_BITS +: BIN_BITS];
  assign sel_b = req_b[gnt_idx*BIN_BITS +: BIN_BITS];

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d    = sel_a;
          b_d    = sel_b;
          id_d   = gnt_idx;
          ptr_d  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          prod_d = '0;
          cyc_d  = '0;
          state_d = (sel_a == '0 || sel_b == '0) ? RESP : FEED;
        end
      end
      FEED: begin
        if (mul_out && prod_q != '1) prod_d = prod_q + PW'(1);
        if (cyc_q == 32'(U_BITS - 1)) begin
          state_d = DRAIN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      DRAIN: begin
        if (mul_out && prod_q != '1) prod_d = prod_q + PW'(1);
        if (cyc_q == 32'(DRAIN_CYCLES - 1)) begin
          state_d = RESP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream bits are computed from next-cycle values so they line up with the FEED cycles.
  always_comb begin
    mul_in_valid_d = (state_d == FEED);
    mul_in_a_d     = (state_d == FEED) && (cyc_d < 32'(a_d));
    mul_in_b_d     = (state_d == FEED) && (cyc_d < 32'(b_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cyc_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= '0;
      ptr_q          <= '0;
      prod_q         <= '0;
      mul_in_a_q     <= 1'b0;
      mul_in_b_q     <= 1'b0;
      mul_in_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      a_q            <= a_d;
      b_q            <= b_d;
      id_q           <= id_d;
      ptr_q          <= ptr_d;
      prod_q         <= prod_d;
      mul_in_a_q     <= mul_in_a_d;
      mul_in_b_q     <= mul_in_b_d;
      mul_in_valid_q <= mul_in_valid_d;
    end
  end

  assign req_ready    = (state_q == IDLE && gnt_found && !reset) ?
                        (NUM_REQ'(1) << gnt_idx) : '0;
  assign mul_in_a     = mul_in_a_q;
  assign mul_in_b     = mul_in_b_q;
  assign mul_in_valid = mul_in_valid_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_unary_mult_scheduler.sv
// Bench for unary_mult_scheduler: job-level reference model compared every cycle,
// a behavioural unary multiplier on the serial port, and directed literal checks.
module tb_unary_mult_scheduler;

  localparam int BB = 4;
  localparam int N  = 4;
  localparam int U  = 16;
  localparam int D  = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*BB-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          mul_in_a, mul_in_b, mul_in_valid;
  logic          mul_out = 1'b0;
  logic          resp_valid, resp_ready;
  logic [1:0]    resp_id;
  logic [2*BB-1:0] resp_product;
  logic          busy;
  logic [1:0]    dbg_state;

  unary_mult_scheduler #(.BIN_BITS(BB), .NUM_REQ(N), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_in_valid(mul_in_valid), .mul_out(mul_out), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_product(resp_product),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int j = 0; j < N; j++)
      if (v[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  // ---------------- reference model (job level) ----------------
  bit m_started = 0, m_active = 0, m_nz = 0, m_after_reset = 0;
  bit mul_stuck = 0;
  int m_t0 = 0, m_lat = 0, m_a = 0, m_b = 0, m_id = 0, m_ptr = 0, m_prod = 0;

  always @(posedge clk) begin : model
    int g;
    if (reset) begin
      m_started = 1; m_active = 0; m_ptr = 0; m_after_reset = 1;
    end else if (m_started) begin
      m_after_reset = 0;
      if (!m_active) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_active = 1;
          m_t0  = cyc;
          m_id  = g;
          m_a   = int'(req_a[g*BB +: BB]);
          m_b   = int'(req_b[g*BB +: BB]);
          m_nz  = (m_a != 0) && (m_b != 0);
          m_lat = m_nz ? U + D + 1 : 1;
          if (!m_nz) m_prod = 0;
          else if (mul_stuck) m_prod = (U + D > 255) ? 255 : U + D;
          else m_prod = m_a * m_b;
          m_ptr = (g + 1) % N;
        end
      end else if (cyc - m_t0 >= m_lat && resp_ready) begin
        m_active = 0;
      end
    end
    cyc++;
  end

  // ---------------- behavioural unary multiplier ----------------
  int ca = 0, cb = 0, rem = 0;
  bit pend = 0;
  always @(posedge clk) begin
    if (reset) begin
      ca = 0; cb = 0; rem = 0; pend = 0;
    end else if (mul_in_valid === 1'b1) begin
      ca += int'(mul_in_a); cb += int'(mul_in_b); pend = 1;
    end else if (pend) begin
      rem = ca * cb; ca = 0; cb = 0; pend = 0;
    end
    #1;
    if (mul_stuck) mul_out = 1'b1;
    else if (rem > 0) begin mul_out = 1'b1; rem--; end
    else mul_out = 1'b0;
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin : cmp
      int t, g;
      logic [N-1:0] e_rr;
      bit e_mv, e_rv;
      t = cyc - m_t0;
      e_rr = '0;
      if (!m_active && !reset) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) e_rr[g] = 1'b1;
      end
      e_mv = m_active && m_nz && (t >= 1) && (t <= U);
      e_rv = m_active && (t >= m_lat);
      chk("req_ready", 32'(req_ready), 32'(e_rr));
      chk("mul_in_valid", 32'(mul_in_valid), 32'(e_mv));
      chk("mul_in_a", 32'(mul_in_a), 32'(e_mv && (t - 1 < m_a)));
      chk("mul_in_b", 32'(mul_in_b), 32'(e_mv && (t - 1 < m_b)));
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("busy", 32'(busy), 32'(m_active));
      if (e_rv) begin
        chk("resp_id", 32'(resp_id), 32'(m_id));
        chk("resp_product", 32'(resp_product), 32'(m_prod));
      end
      if (m_after_reset) begin
        chk("reset_resp_id", 32'(resp_id), 32'd0);
        chk("reset_resp_product", 32'(resp_product), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input int a, input int b);
    req_a[i*BB +: BB] = BB'(a);
    req_b[i*BB +: BB] = BB'(b);
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_grant(output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin ok = 1; t = cyc; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got no grant, expected one within 500 cycles");
    end
  endtask

  task automatic wait_resp(output int t, output int nv, output int na, output int nb);
    bit ok = 0;
    t = -1; nv = 0; na = 0; nb = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      nv += int'(mul_in_valid); na += int'(mul_in_a); nb += int'(mul_in_b);
      if (resp_valid === 1'b1) begin ok = 1; t = cyc; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no response, expected one within 500 cycles");
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_mul_in_valid"}, 32'(mul_in_valid), 32'd0);
    chk({tag, "_mul_in_a"}, 32'(mul_in_a), 32'd0);
    chk({tag, "_mul_in_b"}, 32'(mul_in_b), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_resp_product"}, 32'(resp_product), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  int ord[5]   = '{0, 1, 2, 3, 0};
  int lats[5]  = '{273, 1, 273, 1, 273};
  int prods[5] = '{8, 0, 15, 0, 225};
  int nvs[5]   = '{16, 0, 16, 0, 16};
  int nas[5]   = '{2, 0, 3, 0, 15};
  int nbs[5]   = '{4, 0, 5, 0, 15};

  initial begin
    int tg, tr, nv, na, nb;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 2, 4); set_req(1, 0, 9); set_req(2, 3, 5); set_req(3, 6, 0);

    // all four held high: order 0,1,2,3,0, each grant one cycle after acceptance
    tr = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(tg);
      chk("grant_order", 32'(req_ready), 32'(1 << ord[g]));
      if (g > 0) chk("grant_gap", 32'(tg - tr), 32'd1);
      @(posedge clk); #1;
      if (g == 0) set_req(0, 15, 15);
      if (g == 4) req_valid = '0;
      wait_resp(tr, nv, na, nb);
      chk("latency", 32'(tr - tg), 32'(lats[g]));
      chk("job_id", 32'(resp_id), 32'(ord[g]));
      chk("job_product", 32'(resp_product), 32'(prods[g]));
      chk("feed_cycles", 32'(nv), 32'(nvs[g]));
      chk("a_ones", 32'(na), 32'(nas[g]));
      chk("b_ones", 32'(nb), 32'(nbs[g]));
    end

    // stuck-at-1 multiplier output saturates; response held under back-pressure
    @(posedge clk); #1;
    mul_stuck = 1; resp_ready = 1'b0;
    set_req(1, 15, 15); set_req(3, 1, 1);
    wait_grant(tg);
    chk("stall_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(tr, nv, na, nb);
    chk("stall_latency", 32'(tr - tg), 32'd273);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
      chk("stall_resp_id", 32'(resp_id), 32'd1);
      chk("stall_resp_product", 32'(resp_product), 32'd255);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1; req_valid = '0; mul_stuck = 0;

    // reset mid-DRAIN with requester 1 pending
    @(posedge clk); #1;
    set_req(2, 3, 5);
    wait_grant(tg);
    chk("drain_job_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (100) @(posedge clk);
    #1;
    set_req(1, 4, 4);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tg = cyc;
    chk("post_reset_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(tr, nv, na, nb);
    chk("post_reset_latency", 32'(tr - tg), 32'd273);
    chk("post_reset_id", 32'(resp_id), 32'd1);
    chk("post_reset_product", 32'(resp_product), 32'd16);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_mult_scheduler.md
UNARY_MULT_SCHEDULER -- requirements
Module: unary_mult_scheduler

Interface
REQ-001 SHALL have parameter BIN_BITS, default 4, binary operand width; U_BITS = 2^BIN_BITS.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (>=2).
REQ-003 SHALL have parameter DRAIN_CYCLES, default U_BITS*U_BITS+4, number of cycles the multiplier output is sampled after feeding.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 req_a, req_b  input  NUM_REQ*BIN_BITS each  flattened binary operands; requester i at bits [i*BIN_BITS +: BIN_BITS].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-009 mul_in_a, mul_in_b, mul_in_valid  output  1 each  serial unary operand stream to the shared unary multiplier.
REQ-010 mul_out  input  1  serial unary product from the multiplier.
REQ-011 resp_valid  output  1; resp_ready  input  1; resp_id  output  clog2(NUM_REQ); resp_product  output  2*BIN_BITS.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, FEED, DRAIN, RESP.
REQ-014 IDLE: if any req_valid set, SHALL assert req_ready for exactly one requester that cycle, chosen round-robin starting at (last granted + 1) mod NUM_REQ; SHALL capture req_a, req_b and the index.
REQ-015 req_ready SHALL be combinational from req_valid and the pointer, and SHALL be zero outside IDLE.
REQ-016 Round-robin pointer SHALL update only on a transfer.
REQ-017 On transfer, if captured a==0 or b==0, SHALL go directly to RESP with product 0; mul_in_valid SHALL stay low for that job.
REQ-018 Otherwise SHALL go to FEED for exactly U_BITS cycles, k = 0..U_BITS-1: mul_in_valid=1, mul_in_a=(k<a), mul_in_b=(k<b).
REQ-019 mul_in_a, mul_in_b, mul_in_valid SHALL be registered and SHALL be 0 outside FEED.
REQ-020 SHALL clear a product counter of 2*BIN_BITS bits on entry to FEED and increment it on every cycle of FEED and DRAIN in which mul_out==1.
REQ-021 Product counter SHALL saturate at all-ones and never wrap.
REQ-022 After FEED SHALL stay in DRAIN for exactly DRAIN_CYCLES cycles, then go to RESP.
REQ-023 RESP: resp_valid=1, with resp_id, resp_product registered and stable until resp_ready; on resp_valid && resp_ready SHALL return to IDLE.
REQ-024 No new grant SHALL occur in the cycle of response acceptance; the earliest next grant is the following IDLE cycle.
REQ-025 Latency, nonzero operands: resp_valid rises U_BITS+DRAIN_CYCLES+1 cycles after the transfer cycle; zero operand: 1 cycle after.
REQ-026 req_valid changes outside IDLE SHALL have no effect; captured operands are immune to later input changes.

Reset
REQ-027 With reset high at a rising edge, the next cycle SHALL have state IDLE, pointer 0 (requester 0 highest priority), counter 0, and all outputs 0: req_ready, mul_*, resp_valid, resp_id, resp_product, busy.
REQ-028 Reset in any state, including mid-FEED or mid-DRAIN, SHALL abandon the job without a response; multiplier reset is driven separately at top level.

Verification
REQ-029 U_BITS=16: req 2 sends a=3, b=5 -> mul_in_valid high 16 cycles (a-stream 1,1,1,0..., b-stream five 1s), resp_valid at transfer+273, resp_id=2, resp_product=15.
REQ-030 a=15, b=15 -> resp_product=225; a mul_out stuck at 1 -> resp_product=255 (saturated).
REQ-031 a=0, b=9 -> mul_in_valid never high, resp_valid at transfer+1, resp_product=0.
REQ-032 After reset, all four req_valid held high -> grant order 0,1,2,3,0, with each new grant only after the prior response is accepted.
REQ-033 resp_ready low for 10 cycles in RESP -> resp_valid, resp_id, resp_product held stable, req_ready stays 0, busy=1.
REQ-034 Reset asserted mid-DRAIN with req 1 pending -> all outputs 0 the next cycle, no response, and req 1 is granted on the first IDLE cycle after reset drops.
